// File: rtl/tile_draw_engine.sv
// Renders one grid tile as a TILE_PX x TILE_PX RGB565 square over an 8080-style 8-bit LCD write bus.
// Optional GRID_LINES_EN: right column and bottom row of each non-border tile are drawn in grey 0x4208.
module tile_draw_engine #(
    parameter int TILE_PX = 20,
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 12
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       draw_req,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       cmd_done,
    output logic       busy,
    output logic       lcd_cs_n,
    output logic       lcd_wr_n,
    output logic       lcd_dcx,
    output logic [7:0] lcd_data
);
    // Handshake: draw_req is sampled only in IDLE; cmd_done is a one-cycle pulse
    // ending every accepted request (rendered or rejected); no back-pressure on the bus.
    localparam int CW = (TILE_PX > 1) ? $clog2(TILE_PX) : 1;
    localparam logic [CW-1:0] LAST = CW'(TILE_PX - 1);
    localparam logic [15:0]   TP16 = 16'(TILE_PX);

    typedef enum logic [2:0] {S_IDLE, S_REJECT, S_CMD, S_PARAM, S_PIX, S_DONE} state_t;
    state_t state;

    logic [3:0]    x_q, y_q;
    logic [2:0]    obj_q;
    logic [3:0]    byte_idx;
    logic [CW-1:0] col, row;
    logic          lo_byte;

    logic [15:0] x0, x1, y0, y1;
    assign x0 = 16'(x_q) * TP16;
    assign x1 = x0 + TP16 - 16'd1;
    assign y0 = 16'(y_q) * TP16;
    assign y1 = y0 + TP16 - 16'd1;

    logic [3:0] nxt_idx;
    logic       nxt_is_cmd;
    logic [7:0] hdr_byte;
    assign nxt_idx    = byte_idx + 4'd1;
    assign nxt_is_cmd = (nxt_idx == 4'd5) || (nxt_idx == 4'd10);

    // Header: CASET opcode + 4 params, PASET opcode + 4 params, RAMWR opcode.
    always_comb begin
        hdr_byte = 8'h2A;
        case (nxt_idx)
            4'd1:    hdr_byte = x0[15:8];
            4'd2:    hdr_byte = x0[7:0];
            4'd3:    hdr_byte = x1[15:8];
            4'd4:    hdr_byte = x1[7:0];
            4'd5:    hdr_byte = 8'h2B;
            4'd6:    hdr_byte = y0[15:8];
            4'd7:    hdr_byte = y0[7:0];
            4'd8:    hdr_byte = y1[15:8];
            4'd9:    hdr_byte = y1[7:0];
            4'd10:   hdr_byte = 8'h2C;
            default: hdr_byte = 8'h2A;
        endcase
    end

    logic          last_col, last_row;
    logic [CW-1:0] nxt_col, nxt_row;
    assign last_col = (col == LAST);
    assign last_row = (row == LAST);
    assign nxt_col  = last_col ? '0 : col + 1'b1;
    assign nxt_row  = last_col ? row + 1'b1 : row;

    function automatic logic [15:0] obj_colour(input logic [2:0] code);
        case (code)
            3'd0:    return 16'h0000;
            3'd1:    return 16'h07E0;
            3'd2:    return 16'h03E0;
            3'd3:    return 16'hF800;
            3'd4:    return 16'hFFFF;
            default: return 16'hF81F;
        endcase
    endfunction

    // cur_colour is the pixel now on the bus, nxt_colour the one loaded after its low byte.
    logic [15:0] cur_colour, nxt_colour;
    always_comb begin
        cur_colour = obj_colour(obj_q);
        nxt_colour = cur_colour;
`ifdef GRID_LINES_EN
        if (obj_q != 3'd4 && (last_col || last_row))
            cur_colour = 16'h4208;
        if (obj_q != 3'd4 && (nxt_col == LAST || nxt_row == LAST))
            nxt_colour = 16'h4208;
`endif
    end

    // Phase A is marked by lcd_wr_n=0; each phase-B cycle either loads the next byte or finishes.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            cmd_done <= 1'b0;
            busy     <= 1'b0;
            lcd_cs_n <= 1'b1;
            lcd_wr_n <= 1'b1;
            lcd_dcx  <= 1'b1;
            lcd_data <= 8'h00;
            x_q      <= '0;
            y_q      <= '0;
            obj_q    <= '0;
            byte_idx <= '0;
            col      <= '0;
            row      <= '0;
            lo_byte  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_done <= 1'b0;
                    busy     <= 1'b0;
                    if (draw_req) begin
                        x_q      <= x;
                        y_q      <= y;
                        obj_q    <= obj_code;
                        byte_idx <= '0;
                        col      <= '0;
                        row      <= '0;
                        lo_byte  <= 1'b0;
                        if (32'(x) >= GRID_W || 32'(y) >= GRID_H) begin
                            state    <= S_REJECT;
                            cmd_done <= 1'b1;
                        end else begin
                            state    <= S_CMD;
                            busy     <= 1'b1;
                            lcd_cs_n <= 1'b0;
                            lcd_wr_n <= 1'b0;
                            lcd_dcx  <= 1'b0;
                            lcd_data <= 8'h2A;
                        end
                    end
                end
                S_REJECT: begin
                    cmd_done <= 1'b0;
                    state    <= S_IDLE;
                end
                S_CMD, S_PARAM: begin
                    if (!lcd_wr_n) begin
                        lcd_wr_n <= 1'b1;
                    end else begin
                        lcd_wr_n <= 1'b0;
                        if (byte_idx == 4'd10) begin
                            state    <= S_PIX;
                            lcd_dcx  <= 1'b1;
                            lcd_data <= cur_colour[15:8];
                            lo_byte  <= 1'b0;
                        end else begin
                            byte_idx <= nxt_idx;
                            state    <= nxt_is_cmd ? S_CMD : S_PARAM;
                            lcd_dcx  <= !nxt_is_cmd;
                            lcd_data <= hdr_byte;
                        end
                    end
                end
                S_PIX: begin
                    if (!lcd_wr_n) begin
                        lcd_wr_n <= 1'b1;
                    end else if (!lo_byte) begin
                        lcd_wr_n <= 1'b0;
                        lo_byte  <= 1'b1;
                        lcd_data <= cur_colour[7:0];
                    end else if (last_col && last_row) begin
                        state    <= S_DONE;
                        lcd_cs_n <= 1'b1;
                        cmd_done <= 1'b1;
                        lcd_data <= 8'h00;
                    end else begin
                        lcd_wr_n <= 1'b0;
                        lo_byte  <= 1'b0;
                        col      <= nxt_col;
                        row      <= nxt_row;
                        lcd_data <= nxt_colour[15:8];
                    end
                end
                S_DONE: begin
                    cmd_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_draw_engine.sv
// Bench for tile_draw_engine: randomized tile requests checked against a byte-stream model.
// Honours GRID_LINES_EN in the model when the macro is defined.
module tb_tile_draw_engine;
    localparam int TP  = 20;
    localparam int LAT = 1 + 2 * (11 + 2 * TP * TP);

    logic       tb_clk = 1'b0;
    logic       nrst = 1'b0;
    logic       draw_req = 1'b0;
    logic [3:0] x = '0;
    logic [3:0] y = '0;
    logic [2:0] obj_code = '0;
    logic       cmd_done, busy, lcd_cs_n, lcd_wr_n, lcd_dcx;
    logic [7:0] lcd_data;

    tile_draw_engine #(.TILE_PX(TP), .GRID_W(16), .GRID_H(12)) dut (
        .clk(tb_clk), .nrst(nrst), .draw_req(draw_req), .x(x), .y(y), .obj_code(obj_code),
        .cmd_done(cmd_done), .busy(busy), .lcd_cs_n(lcd_cs_n), .lcd_wr_n(lcd_wr_n),
        .lcd_dcx(lcd_dcx), .lcd_data(lcd_data)
    );

    always #5 tb_clk = ~tb_clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    bit         cap_en = 1'b0;
    int         cs_wr_bad = 0;

    // Every rising write strobe is a byte latched by the panel.
    always @(posedge lcd_wr_n) begin
        if (cap_en) begin
            got_q.push_back({lcd_dcx, lcd_data});
            if (lcd_cs_n !== 1'b0) cs_wr_bad++;
        end
    end

    function automatic logic [15:0] model_colour(input int obj);
        case (obj)
            0: return 16'h0000;
            1: return 16'h07E0;
            2: return 16'h03E0;
            3: return 16'hF800;
            4: return 16'hFFFF;
            default: return 16'hF81F;
        endcase
    endfunction

    task automatic push_model(input int tx, input int ty, input int tobj);
        logic [15:0] x0, x1, y0, y1, c;
        x0 = 16'(tx * TP);
        x1 = 16'(tx * TP + TP - 1);
        y0 = 16'(ty * TP);
        y1 = 16'(ty * TP + TP - 1);
        exp_q.push_back({1'b0, 8'h2A});
        exp_q.push_back({1'b1, x0[15:8]}); exp_q.push_back({1'b1, x0[7:0]});
        exp_q.push_back({1'b1, x1[15:8]}); exp_q.push_back({1'b1, x1[7:0]});
        exp_q.push_back({1'b0, 8'h2B});
        exp_q.push_back({1'b1, y0[15:8]}); exp_q.push_back({1'b1, y0[7:0]});
        exp_q.push_back({1'b1, y1[15:8]}); exp_q.push_back({1'b1, y1[7:0]});
        exp_q.push_back({1'b0, 8'h2C});
        for (int r = 0; r < TP; r++) begin
            for (int cc = 0; cc < TP; cc++) begin
                c = model_colour(tobj);
`ifdef GRID_LINES_EN
                if (tobj != 4 && (r == TP - 1 || cc == TP - 1)) c = 16'h4208;
`endif
                exp_q.push_back({1'b1, c[15:8]});
                exp_q.push_back({1'b1, c[7:0]});
            end
        end
    endtask

    int obs_done_cyc, obs_n_done, obs_busy_bad, obs_cs_bad, obs_byte_err;

    // Byte-stream diff: -1 equal, -2 length differs, else first differing index.
    task automatic diff_bytes();
        obs_byte_err = -1;
        if (got_q.size() != exp_q.size()) begin
            obs_byte_err = -2;
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) begin
                    obs_byte_err = i;
                    break;
                end
            end
        end
    endtask

    // Issues one request and observes the DUT cycle by cycle after the accept edge.
    task automatic drive_txn(input int tx, input int ty, input int tobj, input bit valid);
        exp_q.delete();
        got_q.delete();
        cs_wr_bad = 0;
        if (valid) push_model(tx, ty, tobj);
        cap_en = 1'b1;
        @(negedge tb_clk);
        draw_req = 1'b1; x = 4'(tx); y = 4'(ty); obj_code = 3'(tobj);
        @(posedge tb_clk);
        obs_done_cyc = -1; obs_n_done = 0; obs_busy_bad = 0; obs_cs_bad = 0;
        for (int k = 1; k <= LAT + 40; k++) begin
            @(negedge tb_clk);
            if (k == 1) begin
                draw_req = 1'b0;
                x = 4'($urandom_range(15, 0));
                y = 4'($urandom_range(15, 0));
                obj_code = 3'($urandom_range(7, 0));
            end
            if (cmd_done === 1'b1) begin
                obs_n_done++;
                if (obs_done_cyc < 0) obs_done_cyc = k;
            end
            if (busy !== (valid && k <= LAT)) obs_busy_bad++;
            if (lcd_cs_n !== !(valid && k < LAT)) obs_cs_bad++;
            if (obs_done_cyc > 0 && k >= obs_done_cyc + 2) break;
        end
        cap_en = 1'b0;
        diff_bytes();
    endtask

    task automatic test_reset();
        nrst = 1'b0; draw_req = 1'b1; x = 4'd4; y = 4'd4; obj_code = 3'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            n_cmp++;
            if ({lcd_cs_n, lcd_wr_n, lcd_dcx, lcd_data, cmd_done, busy} !== {3'b111, 8'h00, 2'b00}) begin
                n_fail++;
                $display("FAIL reset_values cyc %0d got cs_n=%b wr_n=%b dcx=%b data=%h done=%b busy=%b required 1 1 1 00 0 0",
                         i, lcd_cs_n, lcd_wr_n, lcd_dcx, lcd_data, cmd_done, busy);
            end
        end
        draw_req = 1'b0;
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            n_cmp++;
            if (lcd_cs_n !== 1'b1 || busy !== 1'b0 || cmd_done !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_after_reset got cs_n=%b busy=%b done=%b required 1 0 0", lcd_cs_n, busy, cmd_done);
            end
        end
    endtask

    task automatic test_basic();
        drive_txn(4, 4, 1, 1'b1);
        n_cmp++;
        if (obs_done_cyc !== LAT || obs_n_done !== 1) begin
            n_fail++;
            $display("FAIL basic_done got cycle %0d count %0d required cycle %0d count 1", obs_done_cyc, obs_n_done, LAT);
        end
        n_cmp++;
        if (obs_busy_bad !== 0 || obs_cs_bad !== 0 || cs_wr_bad !== 0) begin
            n_fail++;
            $display("FAIL basic_ctrl got busy_err %0d cs_err %0d cs_at_wr_err %0d required 0 0 0", obs_busy_bad, obs_cs_bad, cs_wr_bad);
        end
        n_cmp++;
        if (got_q.size() !== 811 || obs_byte_err !== -1) begin
            n_fail++;
            $display("FAIL basic_bytes got %0d bytes (diff code %0d) required 811 bytes matching model", got_q.size(), obs_byte_err);
        end
    endtask

    task automatic test_corners();
        int tab [2][3] = '{'{15, 11, 4}, '{0, 0, 6}};
        for (int i = 0; i < 2; i++) begin
            drive_txn(tab[i][0], tab[i][1], tab[i][2], 1'b1);
            n_cmp++;
            if (obs_done_cyc !== LAT || obs_n_done !== 1 || obs_busy_bad !== 0 || obs_cs_bad !== 0) begin
                n_fail++;
                $display("FAIL corner%0d_ctrl got done %0d x%0d busy_err %0d cs_err %0d required %0d x1 0 0",
                         i, obs_done_cyc, obs_n_done, obs_busy_bad, obs_cs_bad, LAT);
            end
            n_cmp++;
            if (obs_byte_err !== -1) begin
                n_fail++;
                $display("FAIL corner%0d_bytes got %0d bytes diff code %0d required %0d matching bytes",
                         i, got_q.size(), obs_byte_err, exp_q.size());
            end
        end
    endtask

    task automatic test_reject();
        int ty_tab [2] = '{12, 15};
        for (int i = 0; i < 2; i++) begin
            drive_txn(int'($urandom_range(15, 0)), ty_tab[i], int'($urandom_range(7, 0)), 1'b0);
            n_cmp++;
            if (obs_done_cyc !== 1 || obs_n_done !== 1 || obs_busy_bad !== 0 || obs_cs_bad !== 0 || got_q.size() !== 0) begin
                n_fail++;
                $display("FAIL reject_y%0d got done %0d x%0d busy_err %0d cs_err %0d bytes %0d required 1 x1 0 0 0",
                         ty_tab[i], obs_done_cyc, obs_n_done, obs_busy_bad, obs_cs_bad, got_q.size());
            end
        end
        drive_txn(9, 5, 2, 1'b1);
        n_cmp++;
        if (obs_done_cyc !== LAT || obs_n_done !== 1 || obs_byte_err !== -1) begin
            n_fail++;
            $display("FAIL after_reject got done %0d x%0d diff code %0d required %0d x1 -1", obs_done_cyc, obs_n_done, obs_byte_err, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int  d1, d2, nd;
        bit  idle_ok, acc_ok;
        exp_q.delete(); got_q.delete(); cs_wr_bad = 0;
        push_model(7, 3, 2);
        push_model(2, 9, 5);
        cap_en = 1'b1;
        @(negedge tb_clk);
        draw_req = 1'b1; x = 4'd7; y = 4'd3; obj_code = 3'd2;
        @(posedge tb_clk);
        d1 = -1; d2 = -1; nd = 0; idle_ok = 1'b0; acc_ok = 1'b0;
        for (int k = 1; k <= 2 * LAT + 20; k++) begin
            @(negedge tb_clk);
            if (k == 300) begin
                x = 4'd2; y = 4'd9; obj_code = 3'd5;
            end
            if (cmd_done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            if (k == LAT + 1) idle_ok = (busy === 1'b0 && lcd_cs_n === 1'b1);
            if (k == LAT + 2) begin
                acc_ok = (busy === 1'b1 && lcd_cs_n === 1'b0);
                draw_req = 1'b0;
            end
            if (d2 > 0 && k >= d2 + 2) break;
        end
        cap_en = 1'b0;
        diff_bytes();
        n_cmp++;
        if (d1 !== LAT || d2 !== 2 * LAT + 1 || nd !== 2) begin
            n_fail++;
            $display("FAIL b2b_done got %0d,%0d count %0d required %0d,%0d count 2", d1, d2, nd, LAT, 2 * LAT + 1);
        end
        n_cmp++;
        if (!idle_ok || !acc_ok) begin
            n_fail++;
            $display("FAIL b2b_reaccept got idle_cycle_ok %0d accept_ok %0d required 1 1", idle_ok, acc_ok);
        end
        n_cmp++;
        if (obs_byte_err !== -1 || cs_wr_bad !== 0) begin
            n_fail++;
            $display("FAIL b2b_bytes got %0d bytes diff code %0d cs_at_wr_err %0d required %0d bytes -1 0",
                     got_q.size(), obs_byte_err, cs_wr_bad, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        cap_en = 1'b0;
        @(negedge tb_clk);
        draw_req = 1'b1; x = 4'd5; y = 4'd5; obj_code = 3'd2;
        @(negedge tb_clk);
        draw_req = 1'b0;
        repeat (700) @(negedge tb_clk);
        #2;
        nrst = 1'b0;
        #1;
        n_cmp++;
        if ({lcd_cs_n, lcd_wr_n, lcd_dcx, lcd_data, cmd_done, busy} !== {3'b111, 8'h00, 2'b00}) begin
            n_fail++;
            $display("FAIL midreset_immediate got cs_n=%b wr_n=%b dcx=%b data=%h done=%b busy=%b required 1 1 1 00 0 0",
                     lcd_cs_n, lcd_wr_n, lcd_dcx, lcd_data, cmd_done, busy);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_clk);
            if (cmd_done !== 1'b0 || busy !== 1'b0 || lcd_cs_n !== 1'b1) bad++;
        end
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_clk);
            if (cmd_done !== 1'b0 || busy !== 1'b0 || lcd_cs_n !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet got %0d active cycles required 0", bad);
        end
        drive_txn(1, 2, 3, 1'b1);
        n_cmp++;
        if (obs_done_cyc !== LAT || obs_n_done !== 1 || obs_byte_err !== -1 || obs_cs_bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_next got done %0d x%0d diff code %0d cs_err %0d required %0d x1 -1 0",
                     obs_done_cyc, obs_n_done, obs_byte_err, obs_cs_bad, LAT);
        end
    endtask

    task automatic test_random();
        int tx, ty, to, want;
        bit valid;
        for (int i = 0; i < 4; i++) begin
            tx = int'($urandom_range(15, 0));
            ty = int'($urandom_range(15, 0));
            to = int'($urandom_range(7, 0));
            valid = (ty < 12);
            want = valid ? LAT : 1;
            drive_txn(tx, ty, to, valid);
            n_cmp++;
            if (obs_done_cyc !== want || obs_n_done !== 1 || obs_busy_bad !== 0 || obs_cs_bad !== 0 || obs_byte_err !== -1) begin
                n_fail++;
                $display("FAIL random%0d x=%0d y=%0d obj=%0d got done %0d x%0d busy_err %0d cs_err %0d diff %0d required %0d x1 0 0 -1",
                         i, tx, ty, to, obs_done_cyc, obs_n_done, obs_busy_bad, obs_cs_bad, obs_byte_err, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_reject();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
